processing_element_ws_db: RTL and testbench
===========================================

Name: processing_element_ws_db

Overview:
Next-generation weight-stationary systolic PE with a double-buffered weight: a shadow weight loads over a shift chain while the active weight keeps computing. The PE also has a STAGE-deep valid-tracked multiply pipeline, a global stall, signed/unsigned modes, optional saturating accumulation, and a zero-skip performance counter. One instance sits at each array node. Activations flow east, partial sums flow south, and weights shift south on the load chain.

Parameters:
WIDTH_A, 16, activation width
WIDTH_W, 16, weight width
WIDTH_MAC, 48, partial-sum width; must be >= WIDTH_A+WIDTH_W+1
STAGE, 1, extra multiplier pipeline registers (0..4)
SIGNED, 0, 1 = two's-complement act/weight/psum
SATURATE, 0, 1 = clamp the sum on overflow instead of wrapping
ZERO_GATING, 1, 1 = skip the multiply when an operand is zero
WIDTH_CNT, 16, width of the zero-skip counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
pipeline_en  in  1  global advance; 0 = every pipeline/forwarding register holds
clear  in  1  synchronous clear (see Behaviour)
act_in  in  WIDTH_A  activation from the west
act_valid_in  in  1  act_in/psum_in valid
psum_in  in  WIDTH_MAC  partial sum from the north
act_out  out  WIDTH_A  registered activation to the east
act_valid_out  out  1  registered act_valid_in
psum_out  out  WIDTH_MAC  partial sum to the south
psum_valid_out  out  1  psum_out valid this cycle
wei_in  in  WIDTH_W  weight load-chain input
wei_shift_en  in  1  shift the load chain
wei_out  out  WIDTH_W  shadow weight to the next PE's wei_in
wei_swap  in  1  copy shadow -> active
wei_swap_out  out  1  wei_swap delayed 1 cycle, for the next PE
overflow  out  1  sticky saturation/overflow flag
zero_skip_cnt  out  WIDTH_CNT  count of zero-gated issues

Behaviour:
- Reset (rst=1, async): every register is 0, so all outputs are 0 and both weights are 0.
- Weight path (independent of pipeline_en):
  - wei_shift_en=1: shadow <= wei_in. wei_out is the shadow register, so the chain delay is 1 cycle per PE.
  - wei_swap=1: active <= shadow. wei_swap_out <= wei_swap every cycle.
  - Shift and swap in the same cycle: active takes the OLD shadow value.
- Issue: in a cycle with pipeline_en=1, stage 0 captures {act_valid_in, act_in, psum_in, active weight}.
  - The weight travels with its operand, so a swap never corrupts an in-flight operation.
- Forwarding: when pipeline_en=1, act_out <= act_in and act_valid_out <= act_valid_in (1-cycle latency). When pipeline_en=0, both hold.
- Latency: psum_out for an issued operand appears after STAGE+1 advancing cycles. Cycles with pipeline_en=0 do not count.
  - The valid bit shifts with the data.
  - psum_valid_out is high for exactly one advancing cycle per valid issue.
  - psum_out changes only with a valid result and holds otherwise.
- Arithmetic:
  - Product is WIDTH_A+WIDTH_W bits (signed or unsigned per SIGNED).
  - The product is sign- or zero-extended to WIDTH_MAC, then sum = psum + ext(product).
  - SATURATE=0: wrap modulo 2^WIDTH_MAC; overflow still sets on signed overflow or unsigned carry-out.
  - SATURATE=1: clamp to max/min (signed) or all-ones (unsigned), and set overflow.
- Zero gating (ZERO_GATING=1): an issue with act_valid_in=1 and (act_in==0 or active weight==0) forces the product to 0.
  - Multiplier operand registers hold (no toggle); the result is psum_in passed through with the normal latency.
  - zero_skip_cnt increments and saturates at all-ones.
  - With ZERO_GATING=0 the counter stays 0.
- Invalid issues (act_valid_in=0) never touch overflow or zero_skip_cnt.
- clear=1:
  - Zeroes pipeline data/valids, act_out, act_valid_out, psum_out, psum_valid_out, overflow and zero_skip_cnt, and drops in-flight results.
  - Does NOT clear the shadow weight, the active weight or wei_swap_out.
  - clear overrides pipeline_en.
- rst asserted mid-operation: immediate zeroing of everything, including weights.

Test Plan:
- Weight chain: WIDTH_W=16; shift 0x0003 then 0x0005 through 2 chained PEs, then pulse wei_swap -> PE0 active=0x0005, PE1 active=0x0003; PE1 swaps 1 cycle after PE0.
- Latency: STAGE=1, active=3, act_in=4, psum_in=10, valid for 1 cycle -> psum_out=22 with psum_valid_out high exactly 2 cycles later; insert one pipeline_en=0 cycle mid-flight -> result arrives 3 cycles after issue, value unchanged.
- Swap in flight: issue act=2 with active weight 3, swap to shadow 7 on the next cycle, issue act=2 again -> results 6 then 14 (psum_in=0).
- Signed saturation: SIGNED=1, SATURATE=1, WIDTH_MAC=33, psum_in=2^32-1, act=1, weight=1 -> psum_out=2^32-1 (max) and overflow=1 until clear; SATURATE=0 -> psum_out=-2^32 and overflow=1.
- Zero gating: 5 valid issues with act_in=0 and 2 invalid issues, psum_in=9 -> five results of 9, zero_skip_cnt=5; WIDTH_CNT=2 with 5 skips -> counter stays at 3.
- Clear/reset: clear while 2 results are in flight -> no psum_valid_out, counters 0, and the next issue uses the retained active weight; rst mid-stream -> all outputs 0 and active weight 0.

Source files
------------

// File: rtl/processing_element_ws_db.sv
// Weight-stationary systolic PE with a double-buffered weight (shadow load chain + active copy),
// a STAGE-deep valid-tracked multiply pipeline, global stall, optional saturation and zero-skip counting.
module processing_element_ws_db #(
  parameter int WIDTH_A     = 16,
  parameter int WIDTH_W     = 16,
  parameter int WIDTH_MAC   = 48,
  parameter int STAGE       = 1,
  parameter int SIGNED      = 0,
  parameter int SATURATE    = 0,
  parameter int ZERO_GATING = 1,
  parameter int WIDTH_CNT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipeline_en,
  input  logic                 clear,
  input  logic [WIDTH_A-1:0]   act_in,
  input  logic                 act_valid_in,
  input  logic [WIDTH_MAC-1:0] psum_in,
  output logic [WIDTH_A-1:0]   act_out,
  output logic                 act_valid_out,
  output logic [WIDTH_MAC-1:0] psum_out,
  output logic                 psum_valid_out,
  input  logic [WIDTH_W-1:0]   wei_in,
  input  logic                 wei_shift_en,
  output logic [WIDTH_W-1:0]   wei_out,
  input  logic                 wei_swap,
  output logic                 wei_swap_out,
  output logic                 overflow,
  output logic [WIDTH_CNT-1:0] zero_skip_cnt
);
  localparam int WP = WIDTH_A + WIDTH_W;

  logic [WIDTH_W-1:0]   shadow_q, shadow_d, active_q, active_d;
  logic                 swap_out_q, swap_out_d;
  logic [WIDTH_A-1:0]   act_out_q, act_out_d;
  logic                 act_vout_q, act_vout_d;
  logic                 s0_vld_q, s0_vld_d, s0_zero_q, s0_zero_d;
  logic [WIDTH_A-1:0]   s0_act_q, s0_act_d;
  logic [WIDTH_W-1:0]   s0_wei_q, s0_wei_d;
  logic [WIDTH_MAC-1:0] s0_psum_q, s0_psum_d;
  logic [WIDTH_CNT-1:0] cnt_q, cnt_d;
  logic [WIDTH_MAC-1:0] psum_out_q, psum_out_d;
  logic                 psum_vld_q, psum_vld_d;
  logic                 ovf_q, ovf_d;
  logic                 gate;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    shadow_d   = wei_shift_en ? wei_in : shadow_q;
    active_d   = wei_swap ? shadow_q : active_q;  // same-cycle shift: active takes the old shadow
    swap_out_d = wei_swap;
    gate       = (ZERO_GATING != 0) && act_valid_in && (act_in == '0 || active_q == '0);
    act_out_d  = act_out_q;
    act_vout_d = act_vout_q;
    s0_vld_d   = s0_vld_q;
    s0_zero_d  = s0_zero_q;
    s0_act_d   = s0_act_q;
    s0_wei_d   = s0_wei_q;
    s0_psum_d  = s0_psum_q;
    cnt_d      = cnt_q;
    if (clear) begin
      act_out_d  = '0;
      act_vout_d = 1'b0;
      s0_vld_d   = 1'b0;
      s0_zero_d  = 1'b0;
      s0_act_d   = '0;
      s0_wei_d   = '0;
      s0_psum_d  = '0;
      cnt_d      = '0;
    end else if (pipeline_en) begin
      act_out_d  = act_in;
      act_vout_d = act_valid_in;
      s0_vld_d   = act_valid_in;
      s0_zero_d  = gate;
      s0_psum_d  = psum_in;
      // Gated issues leave the multiplier operands untouched so they do not toggle.
      if (!gate) begin
        s0_act_d = act_in;
        s0_wei_d = active_q;
      end
      if (gate && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      active_q   <= '0;
      swap_out_q <= 1'b0;
      act_out_q  <= '0;
      act_vout_q <= 1'b0;
      s0_vld_q   <= 1'b0;
      s0_zero_q  <= 1'b0;
      s0_act_q   <= '0;
      s0_wei_q   <= '0;
      s0_psum_q  <= '0;
      cnt_q      <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      swap_out_q <= swap_out_d;
      act_out_q  <= act_out_d;
      act_vout_q <= act_vout_d;
      s0_vld_q   <= s0_vld_d;
      s0_zero_q  <= s0_zero_d;
      s0_act_q   <= s0_act_d;
      s0_wei_q   <= s0_wei_d;
      s0_psum_q  <= s0_psum_d;
      cnt_q      <= cnt_d;
    end
  end

  // Operands are extended to WP bits first; the low WP bits of that product are the exact result.
  logic [WP-1:0]        a_ext, w_ext, prod;
  logic [WIDTH_MAC-1:0] prod_ext;
  always_comb begin
    a_ext    = {{WIDTH_W{(SIGNED != 0) && s0_act_q[WIDTH_A-1]}}, s0_act_q};
    w_ext    = {{WIDTH_A{(SIGNED != 0) && s0_wei_q[WIDTH_W-1]}}, s0_wei_q};
    prod     = s0_zero_q ? '0 : a_ext * w_ext;
    prod_ext = {{(WIDTH_MAC-WP){(SIGNED != 0) && prod[WP-1]}}, prod};
  end

  logic                 t_vld;
  logic [WIDTH_MAC-1:0] t_prod, t_psum;

  if (STAGE == 0) begin : g_no_stage
    assign t_vld  = s0_vld_q;
    assign t_prod = prod_ext;
    assign t_psum = s0_psum_q;
  end else begin : g_stage
    logic                 p_vld_q  [STAGE];
    logic                 p_vld_d  [STAGE];
    logic [WIDTH_MAC-1:0] p_prod_q [STAGE];
    logic [WIDTH_MAC-1:0] p_prod_d [STAGE];
    logic [WIDTH_MAC-1:0] p_psum_q [STAGE];
    logic [WIDTH_MAC-1:0] p_psum_d [STAGE];

    always_comb begin
      p_vld_d  = p_vld_q;
      p_prod_d = p_prod_q;
      p_psum_d = p_psum_q;
      for (int i = 0; i < STAGE; i++) begin
        if (clear) begin
          p_vld_d[i]  = 1'b0;
          p_prod_d[i] = '0;
          p_psum_d[i] = '0;
        end else if (pipeline_en) begin
          p_vld_d[i]  = (i == 0) ? s0_vld_q  : p_vld_q[(i == 0) ? 0 : i-1];
          p_prod_d[i] = (i == 0) ? prod_ext  : p_prod_q[(i == 0) ? 0 : i-1];
          p_psum_d[i] = (i == 0) ? s0_psum_q : p_psum_q[(i == 0) ? 0 : i-1];
        end
      end
    end

    // NOTE: the pipeline arrays are small flop stages, not RAM, so they are reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < STAGE; i++) begin
          p_vld_q[i]  <= 1'b0;
          p_prod_q[i] <= '0;
          p_psum_q[i] <= '0;
        end
      end else begin
        p_vld_q  <= p_vld_d;
        p_prod_q <= p_prod_d;
        p_psum_q <= p_psum_d;
      end
    end

    assign t_vld  = p_vld_q[STAGE-1];
    assign t_prod = p_prod_q[STAGE-1];
    assign t_psum = p_psum_q[STAGE-1];
  end

  logic [WIDTH_MAC:0]   sum_full;
  logic [WIDTH_MAC-1:0] sum_wrap, sat_val, result;
  logic                 ovf;
  always_comb begin
    sum_full = {1'b0, t_psum} + {1'b0, t_prod};
    sum_wrap = sum_full[WIDTH_MAC-1:0];
    if (SIGNED != 0) begin
      ovf     = (t_psum[WIDTH_MAC-1] == t_prod[WIDTH_MAC-1]) &&
                (sum_wrap[WIDTH_MAC-1] != t_psum[WIDTH_MAC-1]);
      sat_val = t_psum[WIDTH_MAC-1] ? {1'b1, {(WIDTH_MAC-1){1'b0}}} : {1'b0, {(WIDTH_MAC-1){1'b1}}};
    end else begin
      ovf     = sum_full[WIDTH_MAC];
      sat_val = '1;
    end
    result     = ((SATURATE != 0) && ovf) ? sat_val : sum_wrap;
    psum_out_d = psum_out_q;
    psum_vld_d = psum_vld_q;
    ovf_d      = ovf_q;
    if (clear) begin
      psum_out_d = '0;
      psum_vld_d = 1'b0;
      ovf_d      = 1'b0;
    end else if (pipeline_en) begin
      psum_vld_d = t_vld;
      if (t_vld) psum_out_d = result;
      if (t_vld && ovf) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum_out_q <= '0;
      psum_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      psum_out_q <= psum_out_d;
      psum_vld_q <= psum_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign act_out        = act_out_q;
  assign act_valid_out  = act_vout_q;
  assign psum_out       = psum_out_q;
  assign psum_valid_out = psum_vld_q;
  assign wei_out        = shadow_q;
  assign wei_swap_out   = swap_out_q;
  assign overflow       = ovf_q;
  assign zero_skip_cnt  = cnt_q;
endmodule

// File: tb/tb_processing_element_ws_db.sv
// Directed bench: a two-PE weight chain plus signed-saturating, signed-wrapping and narrow-counter variants.
module tb_processing_element_ws_db;
  logic        clk = 1'b0;
  logic        rst, pipeline_en, clear, act_valid_in, wei_shift_en, wei_swap;
  logic [15:0] act_in, wei_in;
  logic [47:0] psum_in;
  logic [32:0] psum33;

  logic [15:0] a_act_out, b_act_out, s_act_out, w_act_out, c_act_out;
  logic        a_avo, b_avo, s_avo, w_avo, c_avo;
  logic [47:0] a_psum, b_psum, c_psum;
  logic [32:0] s_psum, w_psum;
  logic        a_pv, b_pv, s_pv, w_pv, c_pv;
  logic [15:0] a_wei_out, b_wei_out, s_wei_out, w_wei_out, c_wei_out;
  logic        a_swo, b_swo, s_swo, w_swo, c_swo;
  logic        a_ovf, b_ovf, s_ovf, w_ovf, c_ovf;
  logic [15:0] a_cnt, b_cnt, s_cnt, w_cnt;
  logic [1:0]  c_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  processing_element_ws_db u_a (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .clear(clear),
    .act_in(act_in), .act_valid_in(act_valid_in), .psum_in(psum_in),
    .act_out(a_act_out), .act_valid_out(a_avo), .psum_out(a_psum), .psum_valid_out(a_pv),
    .wei_in(wei_in), .wei_shift_en(wei_shift_en), .wei_out(a_wei_out),
    .wei_swap(wei_swap), .wei_swap_out(a_swo), .overflow(a_ovf), .zero_skip_cnt(a_cnt));

  processing_element_ws_db u_b (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .clear(clear),
    .act_in(act_in), .act_valid_in(act_valid_in), .psum_in(psum_in),
    .act_out(b_act_out), .act_valid_out(b_avo), .psum_out(b_psum), .psum_valid_out(b_pv),
    .wei_in(a_wei_out), .wei_shift_en(wei_shift_en), .wei_out(b_wei_out),
    .wei_swap(a_swo), .wei_swap_out(b_swo), .overflow(b_ovf), .zero_skip_cnt(b_cnt));

  processing_element_ws_db #(.WIDTH_MAC(33), .SIGNED(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .clear(clear),
    .act_in(act_in), .act_valid_in(act_valid_in), .psum_in(psum33),
    .act_out(s_act_out), .act_valid_out(s_avo), .psum_out(s_psum), .psum_valid_out(s_pv),
    .wei_in(wei_in), .wei_shift_en(wei_shift_en), .wei_out(s_wei_out),
    .wei_swap(wei_swap), .wei_swap_out(s_swo), .overflow(s_ovf), .zero_skip_cnt(s_cnt));

  processing_element_ws_db #(.WIDTH_MAC(33), .SIGNED(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .clear(clear),
    .act_in(act_in), .act_valid_in(act_valid_in), .psum_in(psum33),
    .act_out(w_act_out), .act_valid_out(w_avo), .psum_out(w_psum), .psum_valid_out(w_pv),
    .wei_in(wei_in), .wei_shift_en(wei_shift_en), .wei_out(w_wei_out),
    .wei_swap(wei_swap), .wei_swap_out(w_swo), .overflow(w_ovf), .zero_skip_cnt(w_cnt));

  processing_element_ws_db #(.WIDTH_CNT(2)) u_cnt2 (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en), .clear(clear),
    .act_in(act_in), .act_valid_in(act_valid_in), .psum_in(psum_in),
    .act_out(c_act_out), .act_valid_out(c_avo), .psum_out(c_psum), .psum_valid_out(c_pv),
    .wei_in(wei_in), .wei_shift_en(wei_shift_en), .wei_out(c_wei_out),
    .wei_swap(wei_swap), .wei_swap_out(c_swo), .overflow(c_ovf), .zero_skip_cnt(c_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Load a value into the shadow of u_a/u_sat/u_wrap/u_cnt2 and copy it to the active weight.
  task automatic load_weight(input logic [15:0] w);
    wei_in = w; wei_shift_en = 1'b1;
    tick();
    wei_shift_en = 1'b0; wei_swap = 1'b1;
    tick();
    wei_swap = 1'b0;
  endtask

  initial begin
    int zp[7];
    zp = '{1, 1, 0, 1, 0, 1, 1};
    rst = 1'b1; pipeline_en = 1'b1; clear = 1'b0; act_in = '0; act_valid_in = 1'b0;
    psum_in = '0; psum33 = '0; wei_in = '0; wei_shift_en = 1'b0; wei_swap = 1'b0;
    tick(); tick();
    check("rst_psum", a_psum, 0);
    check("rst_pvalid", a_pv, 0);
    check("rst_act_out", a_act_out, 0);
    check("rst_wei_out", a_wei_out, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_ovf", a_ovf, 0);
    rst = 1'b0;
    tick();

    // Weight chain through two PEs, then a swap that ripples one cycle per PE.
    wei_in = 16'h0003; wei_shift_en = 1'b1; tick();
    wei_in = 16'h0005; tick();
    wei_shift_en = 1'b0;
    check("chain_pe0", a_wei_out, 16'h0005);
    check("chain_pe1", b_wei_out, 16'h0003);
    wei_swap = 1'b1; tick();
    check("swap_out_pe0", a_swo, 1);
    check("swap_out_pe1_early", b_swo, 0);
    wei_swap = 1'b0; tick();
    check("swap_out_pe0_drop", a_swo, 0);
    check("swap_out_pe1", b_swo, 1);
    act_in = 16'd1; act_valid_in = 1'b1; psum_in = '0; tick();
    act_valid_in = 1'b0;
    check("fwd_act", a_act_out, 1);
    check("fwd_valid", a_avo, 1);
    tick();
    check("chain_res_early", a_pv, 0);
    tick();
    check("active_pe0", a_psum, 5);
    check("active_pe0_v", a_pv, 1);
    check("active_pe1", b_psum, 3);
    check("active_pe1_v", b_pv, 1);

    // Latency with and without a stall cycle.
    load_weight(16'd3);
    act_in = 16'd4; psum_in = 48'd10; act_valid_in = 1'b1; tick();
    act_valid_in = 1'b0; tick();
    check("lat_early", a_pv, 0);
    tick();
    check("lat_psum", a_psum, 22);
    check("lat_valid", a_pv, 1);
    tick();
    check("lat_one_pulse", a_pv, 0);
    act_valid_in = 1'b1; tick();
    act_valid_in = 1'b0; pipeline_en = 1'b0; tick();
    check("stall_hold", a_pv, 0);
    pipeline_en = 1'b1; tick();
    check("stall_early", a_pv, 0);
    tick();
    check("stall_psum", a_psum, 22);
    check("stall_valid", a_pv, 1);

    // Swap while an operand is in flight: each result keeps its own weight.
    wei_in = 16'd7; wei_shift_en = 1'b1; tick();
    wei_shift_en = 1'b0;
    act_in = 16'd2; psum_in = '0; act_valid_in = 1'b1; wei_swap = 1'b1; tick();
    wei_swap = 1'b0; tick();
    act_valid_in = 1'b0; tick();
    check("inflight_res1", a_psum, 6);
    check("inflight_v1", a_pv, 1);
    tick();
    check("inflight_res2", a_psum, 14);
    check("inflight_v2", a_pv, 1);
    tick();
    check("inflight_done", a_pv, 0);

    // Zero gating: five valid zero activations, two invalid issues.
    act_in = '0; psum_in = 48'd9;
    for (int i = 0; i < 9; i++) begin
      act_valid_in = (i < 7) ? zp[i][0] : 1'b0;
      tick();
      if (i >= 2) begin
        check("zero_valid", a_pv, zp[i-2]);
        if (zp[i-2] == 1) check("zero_psum", a_psum, 9);
      end
    end
    check("zero_cnt", a_cnt, 5);
    check("zero_cnt_sat", c_cnt, 3);
    check("zero_no_ovf", a_ovf, 0);

    // Saturating vs wrapping signed overflow; unsigned carry-out on the 48-bit PE.
    load_weight(16'd1);
    act_in = 16'd1; act_valid_in = 1'b1;
    psum33 = 33'h0_FFFF_FFFF; psum_in = 48'hFFFF_FFFF_FFFF; tick();
    act_valid_in = 1'b0; tick(); tick();
    check("sat_psum", s_psum, 64'h0_FFFF_FFFF);
    check("sat_ovf", s_ovf, 1);
    check("wrap_psum", w_psum, 64'h1_0000_0000);
    check("wrap_ovf", w_ovf, 1);
    check("uns_wrap_psum", a_psum, 0);
    check("uns_ovf", a_ovf, 1);
    tick(); tick(); tick();
    check("sat_ovf_sticky", s_ovf, 1);

    // Clear with two results in flight.
    load_weight(16'd6);
    psum33 = '0; act_in = 16'd3; psum_in = 48'd1; act_valid_in = 1'b1; tick();
    act_in = 16'd5; tick();
    act_valid_in = 1'b0; clear = 1'b1; tick();
    clear = 1'b0;
    check("clr_pvalid", a_pv, 0);
    check("clr_psum", a_psum, 0);
    check("clr_act_out", a_act_out, 0);
    check("clr_ovf", a_ovf, 0);
    check("clr_sat_ovf", s_ovf, 0);
    check("clr_cnt", c_cnt, 0);
    check("clr_wei_kept", a_wei_out, 6);
    tick();
    check("clr_drop1", a_pv, 0);
    tick();
    check("clr_drop2", a_pv, 0);
    act_in = 16'd2; psum_in = '0; act_valid_in = 1'b1; tick();
    act_valid_in = 1'b0; tick(); tick();
    check("clr_active_kept", a_psum, 12);
    check("clr_active_v", a_pv, 1);

    // Asynchronous reset mid-stream.
    act_in = 16'd3; act_valid_in = 1'b1; tick();
    act_valid_in = 1'b0; rst = 1'b1; #2;
    check("arst_psum", a_psum, 0);
    check("arst_act_out", a_act_out, 0);
    check("arst_wei_out", a_wei_out, 0);
    check("arst_fwd_v", a_avo, 0);
    rst = 1'b0;
    act_in = 16'd5; psum_in = 48'd4; act_valid_in = 1'b1; tick();
    act_valid_in = 1'b0; tick(); tick();
    check("arst_weight_zero", a_psum, 4);
    check("arst_weight_v", a_pv, 1);
    check("arst_gated", a_cnt, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
